// File: rtl/fruit_type_gen_6_if.sv
// Request/response bundle for the six-fruit type-code generator.
// The master drives the regeneration requests; the slave returns the type codes and status.
interface fruit_type_gen_6_if;
  logic       init_all;
  logic [5:0] refill_req;
  logic [7:0] fruit1_t;
  logic [7:0] fruit2_t;
  logic [7:0] fruit3_t;
  logic [7:0] fruit4_t;
  logic [7:0] fruit5_t;
  logic [7:0] fruit6_t;
  logic       busy;
  logic       types_valid;

  modport master (
    output init_all,
    output refill_req,
    input  fruit1_t,
    input  fruit2_t,
    input  fruit3_t,
    input  fruit4_t,
    input  fruit5_t,
    input  fruit6_t,
    input  busy,
    input  types_valid
  );

  modport slave (
    input  init_all,
    input  refill_req,
    output fruit1_t,
    output fruit2_t,
    output fruit3_t,
    output fruit4_t,
    output fruit5_t,
    output fruit6_t,
    output busy,
    output types_valid
  );
endinterface

// File: rtl/fruit_type_gen_6.sv
// Regenerates requested fruit type codes from a free-running Galois LFSR, one fruit per cycle.
// Optional macro FRUIT_BALANCE_EN folds values with (v % 3 == 2) down by one or two.
module fruit_type_gen_6 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input logic               clk,
  input logic               reset,
  fruit_type_gen_6_if.slave bus
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic [5:0]  r_pending;
  logic [5:0]  w_clr;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic [7:0]  w_load_val;
  logic [7:0]  r_fruit [6];
  logic        r_busy;
  logic        r_types_valid;

  always_comb begin
    w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 16'h0000);
  end

`ifdef FRUIT_BALANCE_EN
  logic [7:0] w_v;
  logic [7:0] w_mod3;

  // Splitting the residue-2 values evenly between residues 1 and 0 balances bit0 of (value % 3).
  always_comb begin
    w_v        = r_lfsr[7:0];
    w_mod3     = w_v % 8'd3;
    w_load_val = w_v;
    if (w_mod3 == 8'd2) begin
      w_load_val = r_lfsr[8] ? (w_v - 8'd1) : (w_v - 8'd2);
    end
  end
`else
  always_comb begin
    w_load_val = r_lfsr[7:0];
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_clr        = '0;
    unique case (r_state)
      StIdle: begin
        if (r_pending != 6'b0) begin
          w_state_next = StScan;
          w_idx_next   = 3'd0;
        end
      end
      StScan: begin
        if (r_pending[r_idx]) begin
          w_clr[r_idx] = 1'b1;
        end
        if (r_idx == 3'd5) begin
          w_state_next = StDone;
        end else begin
          w_idx_next = r_idx + 3'd1;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_idx         <= 3'd0;
      r_pending     <= 6'b0;
      r_lfsr        <= SeedEff;
      r_busy        <= 1'b0;
      r_types_valid <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        r_fruit[i] <= 8'h00;
      end
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      // A new request for a fruit being loaded this cycle wins, so it is served again next pass.
      r_pending     <= (r_pending & ~w_clr) | bus.refill_req | {6{bus.init_all}};
      r_lfsr        <= w_lfsr_next;
      r_busy        <= (w_state_next == StScan) || (w_state_next == StDone);
      r_types_valid <= (w_state_next == StDone);
      for (int i = 0; i < 6; i++) begin
        if (w_clr[i]) begin
          r_fruit[i] <= w_load_val;
        end
      end
    end
  end

  assign bus.fruit1_t    = r_fruit[0];
  assign bus.fruit2_t    = r_fruit[1];
  assign bus.fruit3_t    = r_fruit[2];
  assign bus.fruit4_t    = r_fruit[3];
  assign bus.fruit5_t    = r_fruit[4];
  assign bus.fruit6_t    = r_fruit[5];
  assign bus.busy        = r_busy;
  assign bus.types_valid = r_types_valid;

endmodule

// File: tb/tb_fruit_type_gen_6.sv
// Randomised scoreboard bench for fruit_type_gen_6: a timestamp-based reference model pushes
// the expected fruit set of every pass; a monitor pops and compares on each types_valid.
module tb_fruit_type_gen_6;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fruit_type_gen_6_if u_if ();

  fruit_type_gen_6 #(
    .SEED(SEED),
    .TAPS(TAPS)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  typedef struct packed {
    logic [5:0][7:0] f;
    logic [5:0]      mask;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_pulse = 0;
  int   n_loads = 0;
  int   n_mod2 = 0;
  int   n_bit1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_load(input logic [15:0] l);
    logic [7:0] v;
    v = l[7:0];
`ifdef FRUIT_BALANCE_EN
    if ((v % 8'd3) == 8'd2) return l[8] ? v - 8'd1 : v - 8'd2;
`endif
    return v;
  endfunction

  // Reference model: cycles are numbered from reset; a pass starting at cycle ps loads fruit i
  // at cycle ps+i and signals completion at ps+6.
  int              m_cyc;
  int              m_ps;
  logic [15:0]     m_lfsr;
  logic [5:0]      m_pend;
  logic [5:0][7:0] m_fruit;
  logic [5:0]      m_mask;
  bit              m_ready = 1'b0;

  task automatic model_step();
    logic [5:0] clr;
    int         off;
    exp_t       e;
    if (reset) begin
      m_cyc   = 0;
      m_ps    = -100;
      m_lfsr  = SEED;
      m_pend  = '0;
      m_fruit = '0;
      m_mask  = '0;
      m_ready = 1'b1;
      return;
    end
    clr = '0;
    off = m_cyc - m_ps;
    if (off >= 0 && off <= 5) begin
      if (m_pend[off]) begin
        m_fruit[off] = ref_load(m_lfsr);
        clr[off]     = 1'b1;
        m_mask[off]  = 1'b1;
      end
      if (off == 5) begin
        e.f    = m_fruit;
        e.mask = m_mask;
        sb_q.push_back(e);
        m_mask = '0;
      end
    end else if (off != 6 && m_pend != 6'b0) begin
      m_ps = m_cyc + 1;
    end
    m_pend = (m_pend & ~clr) | u_if.refill_req | {6{u_if.init_all}};
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? TAPS : 16'h0000);
    m_cyc++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor
  initial begin
    exp_t            e;
    logic [5:0][7:0] act;
    int              d;
    forever begin
      @(negedge clk);
      if (m_ready) begin
        d = m_cyc - m_ps;
        chk("busy", {31'b0, u_if.busy}, {31'b0, (d >= 0 && d <= 6)});
        chk("types_valid", {31'b0, u_if.types_valid}, {31'b0, (d == 6)});
        if (u_if.types_valid) begin
          n_pulse++;
          act = {u_if.fruit6_t, u_if.fruit5_t, u_if.fruit4_t,
                 u_if.fruit3_t, u_if.fruit2_t, u_if.fruit1_t};
          if (sb_q.size() == 0) begin
            chk("unexpected_pass", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            for (int i = 0; i < 6; i++) begin
              chk($sformatf("fruit%0d_t", i + 1), {24'b0, act[i]}, {24'b0, e.f[i]});
              if (e.mask[i]) begin
                n_loads++;
                if ((act[i] % 8'd3) == 8'd2) n_mod2++;
                if ((act[i] % 8'd3) == 8'd1) n_bit1++;
              end
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic init, input logic [5:0] req);
    u_if.init_all   = init;
    u_if.refill_req = req;
    @(negedge clk);
    u_if.init_all   = 1'b0;
    u_if.refill_req = '0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int first;
    int p0;
    reset           = 1'b1;
    u_if.init_all   = 1'b0;
    u_if.refill_req = '0;
    repeat (2) @(negedge clk);
    chk("reset_fruit1", {24'b0, u_if.fruit1_t}, 32'h0);
    chk("reset_busy", {31'b0, u_if.busy}, 32'h0);

    // init_all in cycle 0 after reset
    reset = 1'b0;
    drive(1'b1, 6'b0);
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      if (u_if.types_valid) begin
        first = k;
        break;
      end
      @(negedge clk);
    end
    chk("init_done_cycle", first, 32'd8);
`ifndef FRUIT_BALANCE_EN
    chk("init_fruit1", {24'b0, u_if.fruit1_t}, 32'h38);
    chk("init_fruit2", {24'b0, u_if.fruit2_t}, 32'h9C);
    chk("init_fruit3", {24'b0, u_if.fruit3_t}, 32'h4E);
    chk("init_fruit4", {24'b0, u_if.fruit4_t}, 32'h27);
    chk("init_fruit5", {24'b0, u_if.fruit5_t}, 32'h13);
    chk("init_fruit6", {24'b0, u_if.fruit6_t}, 32'h89);
`endif
    settle();

    // Single-fruit refill
    p0 = n_pulse;
    drive(1'b0, 6'b000100);
    repeat (12) @(negedge clk);
    chk("refill_one_pulses", n_pulse - p0, 32'd1);

    // Request for already-passed indices during SCAN idx 3 (cycle n+5)
    p0 = n_pulse;
    drive(1'b0, 6'b100000);
    repeat (4) @(negedge clk);
    drive(1'b0, 6'b000011);
    repeat (25) @(negedge clk);
    chk("late_req_pulses", n_pulse - p0, 32'd2);

    // Request for fruit5 in the same cycle it is loaded (cycle n+6)
    p0 = n_pulse;
    drive(1'b0, 6'b010000);
    repeat (5) @(negedge clk);
    drive(1'b0, 6'b010000);
    repeat (25) @(negedge clk);
    chk("same_cycle_pulses", n_pulse - p0, 32'd2);

    // Reset during idx 2 of a pass (cycle n+4)
    p0 = n_pulse;
    drive(1'b0, 6'b111111);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_fruit1", {24'b0, u_if.fruit1_t}, 32'h0);
    chk("rst_mid_fruit2", {24'b0, u_if.fruit2_t}, 32'h0);
    chk("rst_mid_fruit6", {24'b0, u_if.fruit6_t}, 32'h0);
    chk("rst_mid_busy", {31'b0, u_if.busy}, 32'h0);
    repeat (15) @(negedge clk);
    chk("rst_mid_pulses", n_pulse - p0, 32'd0);

    // Randomised traffic
    for (int c = 0; c < 6000; c++) begin
      logic [5:0] r;
      r = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'b0;
      drive(($urandom_range(0, 15) == 0), r);
    end
    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

`ifdef FRUIT_BALANCE_EN
    chk("bal_loads_enough", {31'b0, (n_loads >= 3000)}, 32'd1);
    chk("bal_no_mod2", n_mod2, 32'd0);
    chk("bal_fraction", {31'b0, (n_bit1 * 100 >= n_loads * 45 && n_bit1 * 100 <= n_loads * 55)},
        32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
